spi_reg_frame: RTL and testbench
================================

// Module: spi_reg_frame
// PURPOSE
//  Message layer directly downstream of the SPI byte slave (spi_byte). It consumes the
//  received-byte strobes and supplies the next transmit byte. It interprets each SS frame as
//  [command][data...] and gives the SPI master read/write access to a small register file.
//  Register 0 bit 0 drives the board LED. A local read port exposes all registers to user logic.
// PARAMETERS
//  DEPTH   16    number of 8-bit registers; power of two, 2..128
//  STATUS  8'h55 byte returned on MISO while the command byte is shifting in
//  ADDR_W  $clog2(DEPTH)  localparam; register address width
// PORTS
//  sysClk       in   1       system clock, 50 MHz; all logic on rising edge
//  usrResetNot  in   1       asynchronous, active-low reset
//  frameActive  in   1       SS asserted, already synchronized to sysClk (1 = in frame)
//  rxValid      in   1       one-cycle pulse: byte-layer byte complete
//  rxData       in   8       received byte; valid only when rxValid=1
//  txData       out  8       byte the byte layer shifts out next (MSB first)
//  wrStrobe     out  1       one-cycle pulse when a register is written
//  wrAddr       out  ADDR_W  address of that write
//  wrData       out  8       data of that write
//  usrAddr      in   ADDR_W  local read-port address
//  usrData      out  8       reg[usrAddr]; combinational read
//  LED          out  1       reg[0][0]
// BEHAVIOUR
//  Reset (async, usrResetNot=0): all registers 0; state=IDLE; addr=0; txData=STATUS;
//   wrStrobe=0; wrAddr=0; wrData=0; LED=0.
//  FSM states: IDLE, CMD, WRITE, READ.
//   IDLE : txData=STATUS. frameActive=1 -> CMD.
//   CMD  : on rxValid, decode rxData: bit7=1 write, bit7=0 read; bits[6:0] mod DEPTH -> addr.
//          write -> WRITE, txData=rxData (echo); read -> READ, txData=reg[addr].
//   WRITE: on rxValid: reg[addr]<=rxData; wrStrobe=1, wrAddr=addr, wrData=rxData;
//          addr<=addr+1 mod DEPTH; txData<=rxData (echo).
//   READ : on rxValid: addr<=addr+1 mod DEPTH; txData<=reg[addr+1 mod DEPTH]; rxData ignored.
//   Any state: frameActive=0 -> IDLE next cycle; txData<=STATUS.
//  Latency: txData and wrStrobe are registered and valid 1 sysClk after rxValid. The byte
//   layer needs txData within 12 sysClks (SCLK 4 MHz), so 1-cycle latency is mandatory.
//  Simultaneous rxValid and frameActive falling edge: the byte is processed fully (write
//   committed), then the FSM goes to IDLE.
//  rxValid while IDLE is ignored; no write occurs.
//  Address wrap: DEPTH-1 -> 0 in both READ and WRITE; command bits above ADDR_W are ignored.
//  Frame holding only a command byte: no register changes.
//  Read-during-write: READ and WRITE are never active in the same frame, so there is no conflict.
//   usrData always shows the post-write value from the cycle after wrStrobe.
//  Reset mid-frame: immediate IDLE and clear; the frame remains IDLE until frameActive drops
//   and rises again.
// STRUCTURE
//  Shared package spi_pkg: state encoding (IDLE/CMD/WRITE/READ), CMD_WR_BIT=7, STATUS default.
//  One sub-module: spi_regfile. It holds the DEPTH x 8 flop array with 1 write port and
//   2 async read ports (FSM port and usr port). FSM, address counter and tx mux stay in this module.
// TESTING
//  1 Reset: hold usrResetNot=0 -> txData=55, LED=0, usrData=00 for every usrAddr.
//  2 Frame {81,12,34} -> reg1=12, reg2=34; wrStrobe pulses twice (addr 1,2); MISO bytes 55,81,12.
//  3 Frame {01,00,00} after scenario 2 -> MISO bytes 55,12,34; no wrStrobe.
//  4 Wrap at DEPTH=16: frame {8F,AA,BB} -> reg15=AA, reg0=BB, LED=1; frame {0F,00,00}
//    -> MISO 55,AA,BB.
//  5 SS dropped on the same cycle as rxValid of write byte 0x77 at addr 3 -> reg3=77,
//    then state=IDLE and txData=55.
//  6 Reset asserted mid-WRITE frame after 1 data byte -> all regs 0; later bytes in that
//    frame cause no writes.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-frame message layer.
//   - FSM state encodings (IDLE/CMD/WRITE/READ)
//   - command byte write-flag bit position
//   - default status byte shown on MISO while the command shifts in
package spi_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    localparam int unsigned CMD_WR_BIT     = 7;
    localparam logic [7:0]  STATUS_DEFAULT = 8'h55;

endpackage

// File: rtl/spi_regfile.sv
// DEPTH x 8 register file: one synchronous write port, two asynchronous read ports.
// Ports:
//   sysClk, rstN        clock, async active-low reset (clears every register)
//   we, wAddr, wData    write port
//   rAddrA / rDataA     read port A (frame FSM)
//   rAddrB / rDataB     read port B (user logic)
//   reg0Bit0            bit 0 of register 0
module spi_regfile #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              sysClk,
    input  logic              rstN,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [7:0]        wData,
    input  logic [ADDR_W-1:0] rAddrA,
    output logic [7:0]        rDataA,
    input  logic [ADDR_W-1:0] rAddrB,
    output logic [7:0]        rDataB,
    output logic              reg0Bit0
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wAddr] <= wData;
        end
    end

    assign rDataA   = mem[rAddrA];
    assign rDataB   = mem[rAddrB];
    assign reg0Bit0 = mem[0][0];

endmodule

// File: rtl/spi_reg_frame.sv
// SPI message layer: interprets each SS frame as [command][data...] and gives the
// SPI master read/write access to a small register file.
// Ports:
//   sysClk, usrResetNot   clock, async active-low reset
//   frameActive           synchronized SS (1 = in frame)
//   rxValid, rxData       received-byte strobe and byte from the byte layer
//   txData                next byte to shift out (registered, 1-cycle latency)
//   wrStrobe/wrAddr/wrData  one-cycle write notification
//   usrAddr, usrData      local combinational read port
//   LED                   reg[0][0]
module spi_reg_frame
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter logic [7:0]  STATUS = STATUS_DEFAULT,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              sysClk,
    input  logic              usrResetNot,
    input  logic              frameActive,
    input  logic              rxValid,
    input  logic [7:0]        rxData,
    output logic [7:0]        txData,
    output logic              wrStrobe,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [7:0]        wrData,
    input  logic [ADDR_W-1:0] usrAddr,
    output logic [7:0]        usrData,
    output logic              LED
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] nextAddr;
    logic [ADDR_W-1:0] cmdAddr;
    logic [ADDR_W-1:0] fsmRdAddr;
    logic [7:0]        fsmRdData;
    logic              regWe;
    // Set by reset; a frame already in progress at reset must end before a new one starts.
    logic              waitDrop;

    assign cmdAddr   = rxData[ADDR_W-1:0];
    assign nextAddr  = addr + 1'b1;
    // In CMD the read address comes straight from the command byte so the first
    // read byte is ready one cycle after rxValid.
    assign fsmRdAddr = (state == ST_CMD) ? cmdAddr : nextAddr;
    assign regWe     = (state == ST_WRITE) && rxValid;

    spi_regfile #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) uRegfile (
        .sysClk   (sysClk),
        .rstN     (usrResetNot),
        .we       (regWe),
        .wAddr    (addr),
        .wData    (rxData),
        .rAddrA   (fsmRdAddr),
        .rDataA   (fsmRdData),
        .rAddrB   (usrAddr),
        .rDataB   (usrData),
        .reg0Bit0 (LED)
    );

    always_ff @(posedge sysClk or negedge usrResetNot) begin
        if (!usrResetNot) begin
            state    <= ST_IDLE;
            addr     <= '0;
            txData   <= STATUS;
            wrStrobe <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
            waitDrop <= 1'b1;
        end else begin
            wrStrobe <= 1'b0;
            if (!frameActive) begin
                waitDrop <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    txData <= STATUS;
                    if (frameActive && !waitDrop) begin
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (rxValid) begin
                        addr <= cmdAddr;
                        if (rxData[CMD_WR_BIT]) begin
                            state  <= ST_WRITE;
                            txData <= rxData;
                        end else begin
                            state  <= ST_READ;
                            txData <= fsmRdData;
                        end
                    end
                end
                ST_WRITE: begin
                    if (rxValid) begin
                        wrStrobe <= 1'b1;
                        wrAddr   <= addr;
                        wrData   <= rxData;
                        addr     <= nextAddr;
                        txData   <= rxData;
                    end
                end
                default: begin
                    if (rxValid) begin
                        addr   <= nextAddr;
                        txData <= fsmRdData;
                    end
                end
            endcase
            // Frame end overrides the next state but the byte above is still committed.
            if (!frameActive) begin
                state  <= ST_IDLE;
                txData <= STATUS;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_frame.sv
// Self-checking bench for spi_reg_frame: table of frames with expected MISO bytes,
// a reference register model, and a write-strobe scoreboard queue.
module tb_spi_reg_frame;

    logic       sysClk = 1'b0;
    logic       usrResetNot;
    logic       frameActive;
    logic       rxValid;
    logic [7:0] rxData;
    logic [7:0] txData;
    logic       wrStrobe;
    logic [3:0] wrAddr;
    logic [7:0] wrData;
    logic [3:0] usrAddr;
    logic [7:0] usrData;
    logic       LED;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model [16];
    logic [11:0] wrQ [$];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] m0;
        logic [7:0] m1;
        logic [7:0] m2;
    } frame_t;

    frame_t tbl [6];

    spi_reg_frame #(.DEPTH(16), .STATUS(8'h55)) dut (
        .sysClk      (sysClk),
        .usrResetNot (usrResetNot),
        .frameActive (frameActive),
        .rxValid     (rxValid),
        .rxData      (rxData),
        .txData      (txData),
        .wrStrobe    (wrStrobe),
        .wrAddr      (wrAddr),
        .wrData      (wrData),
        .usrAddr     (usrAddr),
        .usrData     (usrData),
        .LED         (LED)
    );

    always #5 sysClk = ~sysClk;

    // Write scoreboard: every observed strobe must match the oldest expected write.
    always @(negedge sysClk) begin
        if (usrResetNot && wrStrobe) begin
            checks++;
            if (wrQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wrStrobe: got addr=%0h data=%02h, required no write", wrAddr, wrData);
            end else begin
                logic [11:0] exp;
                exp = wrQ.pop_front();
                if ({wrAddr, wrData} !== exp) begin
                    errors++;
                    $display("FAIL wr_contents: got addr=%0h data=%02h, required addr=%0h data=%02h",
                             wrAddr, wrData, exp[11:8], exp[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, required %02h", name, got, exp);
        end
    endtask

    task automatic checkRegs(input string name);
        for (int i = 0; i < 16; i++) begin
            usrAddr = 4'(i);
            #1;
            check8($sformatf("%s_reg%0d", name, i), usrData, model[i]);
        end
        check8({name, "_LED"}, {7'd0, LED}, {7'd0, model[0][0]});
    endtask

    task automatic expectWrite(input logic [3:0] a, input logic [7:0] d);
        wrQ.push_back({a, d});
        model[a] = d;
    endtask

    task automatic sendByte(input string name, input logic [7:0] b, input logic [7:0] expMiso);
        check8(name, txData, expMiso);
        rxData  = b;
        rxValid = 1'b1;
        tick();
        rxValid = 1'b0;
        rxData  = 8'h00;
        repeat (3) tick();
    endtask

    task automatic startFrame();
        frameActive = 1'b1;
        repeat (2) tick();
    endtask

    task automatic endFrame();
        frameActive = 1'b0;
        repeat (3) tick();
        check8("idle_txData", txData, 8'h55);
    endtask

    initial begin
        usrResetNot = 1'b0;
        frameActive = 1'b0;
        rxValid     = 1'b0;
        rxData      = 8'h00;
        usrAddr     = 4'h0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        tbl[0] = '{cmd:8'h81, d0:8'h12, d1:8'h34, m0:8'h55, m1:8'h81, m2:8'h12};
        tbl[1] = '{cmd:8'h01, d0:8'h00, d1:8'h00, m0:8'h55, m1:8'h12, m2:8'h34};
        tbl[2] = '{cmd:8'h8F, d0:8'hAA, d1:8'hBB, m0:8'h55, m1:8'h8F, m2:8'hAA};
        tbl[3] = '{cmd:8'h0F, d0:8'h00, d1:8'h00, m0:8'h55, m1:8'hAA, m2:8'hBB};
        tbl[4] = '{cmd:8'hF1, d0:8'h5A, d1:8'hA5, m0:8'h55, m1:8'hF1, m2:8'h5A};
        tbl[5] = '{cmd:8'h41, d0:8'h00, d1:8'h00, m0:8'h55, m1:8'h5A, m2:8'hA5};

        // Reset state
        repeat (3) tick();
        check8("rst_txData", txData, 8'h55);
        checkRegs("rst");
        usrResetNot = 1'b1;
        repeat (2) tick();

        // Table of complete frames
        for (int f = 0; f < 6; f++) begin
            logic [3:0] a;
            a = tbl[f].cmd[3:0];
            startFrame();
            sendByte($sformatf("f%0d_miso0", f), tbl[f].cmd, tbl[f].m0);
            if (tbl[f].cmd[7]) expectWrite(a, tbl[f].d0);
            sendByte($sformatf("f%0d_miso1", f), tbl[f].d0, tbl[f].m1);
            if (tbl[f].cmd[7]) expectWrite(a + 4'd1, tbl[f].d1);
            sendByte($sformatf("f%0d_miso2", f), tbl[f].d1, tbl[f].m2);
            endFrame();
            checkRegs($sformatf("f%0d", f));
        end

        // Command-only frame: no register change
        startFrame();
        sendByte("cmdonly_miso0", 8'h83, 8'h55);
        endFrame();
        checkRegs("cmdonly");

        // SS drops on the same cycle as the data byte's rxValid
        startFrame();
        sendByte("drop_miso0", 8'h83, 8'h55);
        expectWrite(4'd3, 8'h77);
        check8("drop_miso1", txData, 8'h83);
        rxData      = 8'h77;
        rxValid     = 1'b1;
        frameActive = 1'b0;
        tick();
        rxValid = 1'b0;
        check8("drop_txData", txData, 8'h55);
        repeat (3) tick();
        checkRegs("drop");
        startFrame();
        sendByte("drop_rd_miso0", 8'h03, 8'h55);
        sendByte("drop_rd_miso1", 8'h00, 8'h77);
        endFrame();

        // Reset in the middle of a write frame
        startFrame();
        sendByte("mrst_miso0", 8'h85, 8'h55);
        expectWrite(4'd5, 8'h11);
        sendByte("mrst_miso1", 8'h11, 8'h85);
        usrResetNot = 1'b0;
        #2;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        check8("mrst_txData", txData, 8'h55);
        checkRegs("mrst_in");
        tick();
        usrResetNot = 1'b1;
        tick();
        sendByte("mrst_miso2", 8'h22, 8'h55);
        sendByte("mrst_miso3", 8'h33, 8'h55);
        checkRegs("mrst_after");
        endFrame();
        startFrame();
        sendByte("rec_miso0", 8'h86, 8'h55);
        expectWrite(4'd6, 8'h44);
        sendByte("rec_miso1", 8'h44, 8'h86);
        endFrame();
        checkRegs("rec");

        repeat (3) tick();
        checks++;
        if (wrQ.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d outstanding, required 0", wrQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
